// File: rtl/core_pipe_pkg.sv
// Shared definitions for the RV64 pipeline stage registers: control-bit
// positions, per-stage payload widths and the NOP control word.
package core_pipe_pkg;

    // Control-bit positions inside the ctrl field.
    localparam int CTRL_BRANCH   = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMTOREG = 3;
    localparam int CTRL_REGWRITE = 4;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_ALUOP    = 6;  // ALUop occupies [CTRL_ALUOP+1:CTRL_ALUOP]
    localparam int CTRL_ALUOP_W  = 2;

    // Control width is common to all stages; bit 8 is spare.
    localparam int PIPE_CTRL_W   = 9;

    // Per-stage ctrl/data widths.
    localparam int IF_ID_CTRL_W  = PIPE_CTRL_W;
    localparam int IF_ID_DATA_W  = 96;   // PC + instruction
    localparam int ID_EX_CTRL_W  = PIPE_CTRL_W;
    localparam int ID_EX_DATA_W  = 283;  // PC, RD1, RD2, Immgen, func, func3, rd, rs1, rs2
    localparam int EX_MEM_CTRL_W = PIPE_CTRL_W;
    localparam int EX_MEM_DATA_W = 197;  // PC, ALU result, RD2, rd
    localparam int MEM_WB_CTRL_W = PIPE_CTRL_W;
    localparam int MEM_WB_DATA_W = 133;  // load data, ALU result, rd

    // A NOP carries no side effects: every control bit low.
    localparam logic [PIPE_CTRL_W-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline slot: a valid bit plus ctrl and data fields. Valid and ctrl
// load together; data has its own enable so a NOP or an emptied slot can
// keep its previous payload. Clear kills the entry and zeroes ctrl.
module pipe_skid_slot #(
    parameter int CTRL_W   = 9,
    parameter int DATA_W   = 283,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              load_data,
    input  logic              d_valid,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    // Slot state: reset > clear > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data field is reset as well because the stage must present out_data = 0 after reset.
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            q_data  <= '0;
        end else if (clr) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            q_valid <= 1'b0;
            q_ctrl  <= '0;
            if (CLR_DATA) begin
                q_data <= '0;
            end
        end else begin
            if (load) begin
                q_valid <= d_valid;
                q_ctrl  <= d_ctrl;
            end
            if (load_data) begin
                q_data <= d_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Hazard-aware pipeline stage register: valid/ready handshake, optional
// 2-entry skid buffer, flush and load-use bubble insertion, and saturating
// flush/bubble event counters.
module pipe_stage_reg
    import core_pipe_pkg::*;
#(
    parameter int CTRL_W   = ID_EX_CTRL_W,
    parameter int DATA_W   = ID_EX_DATA_W,
    parameter bit CLR_DATA = 1'b1,
    parameter bit SKID_EN  = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              head_valid;
    logic [CTRL_W-1:0] head_ctrl;
    logic [DATA_W-1:0] head_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    logic              bubble_pend;
    logic              bubble_pend_d;
    logic              bubble_eff;
    logic              bubble_ins;
    logic              head_free;
    logic              stage_ready;
    logic              in_fire;

    logic              head_load;
    logic              head_load_data;
    logic              head_d_valid;
    logic [CTRL_W-1:0] head_d_ctrl;
    logic [DATA_W-1:0] head_d_data;
    logic              skid_load;
    logic              skid_load_data;
    logic              skid_d_valid;
    logic              skid_valid_nxt;

    // A bubble (fresh or pending) holds upstream; flush overrides it.
    assign bubble_eff = (bubble | bubble_pend) & ~flush;
    // The head can take a new entry when it is empty or being consumed.
    assign head_free  = ~head_valid | out_ready;
    assign in_ready   = stage_ready & ~bubble_eff;
    assign in_fire    = in_valid & in_ready;

    assign out_valid  = head_valid;
    assign out_ctrl   = head_ctrl;
    assign out_data   = head_data;

    // Next-entry routing for head and skid: flush > bubble > transfer.
    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        head_load      = 1'b0;
        head_load_data = 1'b0;
        head_d_valid   = 1'b0;
        head_d_ctrl    = CTRL_W'(NOP_CTRL);
        head_d_data    = '0;
        skid_load      = 1'b0;
        skid_load_data = 1'b0;
        skid_d_valid   = 1'b0;
        bubble_ins     = 1'b0;
        bubble_pend_d  = bubble_pend;

        if (flush) begin
            bubble_pend_d = 1'b0;
        end else if (bubble_eff) begin
            if (head_free) begin
                head_load      = 1'b1;
                head_d_valid   = 1'b1;
                head_load_data = CLR_DATA;
                bubble_ins     = 1'b1;
                bubble_pend_d  = 1'b0;
            end else begin
                bubble_pend_d  = 1'b1;
            end
        end else if (head_free) begin
            if (skid_valid) begin
                head_load      = 1'b1;
                head_load_data = 1'b1;
                head_d_valid   = 1'b1;
                head_d_ctrl    = skid_ctrl;
                head_d_data    = skid_data;
                skid_load      = 1'b1;
                skid_d_valid   = in_fire;
                skid_load_data = in_fire;
            end else if (in_fire) begin
                head_load      = 1'b1;
                head_load_data = 1'b1;
                head_d_valid   = 1'b1;
                head_d_ctrl    = in_ctrl;
                head_d_data    = in_data;
            end else if (head_valid) begin
                head_load      = 1'b1;
            end
        end else if (in_fire) begin
            skid_load      = 1'b1;
            skid_d_valid   = 1'b1;
            skid_load_data = 1'b1;
        end
    end

    assign skid_valid_nxt = flush ? 1'b0 : (skid_load ? skid_d_valid : skid_valid);

    pipe_skid_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CLR_DATA (CLR_DATA)
    ) u_head (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .load      (head_load),
        .load_data (head_load_data),
        .d_valid   (head_d_valid),
        .d_ctrl    (head_d_ctrl),
        .d_data    (head_d_data),
        .q_valid   (head_valid),
        .q_ctrl    (head_ctrl),
        .q_data    (head_data)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic rdy_q;

            pipe_skid_slot #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .CLR_DATA (CLR_DATA)
            ) u_skid (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (flush),
                .load      (skid_load),
                .load_data (skid_load_data),
                .d_valid   (skid_d_valid),
                .d_ctrl    (in_ctrl),
                .d_data    (in_data),
                .q_valid   (skid_valid),
                .q_ctrl    (skid_ctrl),
                .q_data    (skid_data)
            );

            // Registered ready tracks an empty skid; low while in reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdy_q <= 1'b0;
                end else begin
                    rdy_q <= ~skid_valid_nxt;
                end
            end

            assign stage_ready = rdy_q;
        end else begin : g_noskid
            assign skid_valid  = 1'b0;
            assign skid_ctrl   = '0;
            assign skid_data   = '0;
            assign stage_ready = out_ready | ~head_valid;
        end
    endgenerate

    // Pending-bubble flag and saturating flush/bubble counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bubble_pend <= 1'b0;
            flush_cnt   <= '0;
            bubble_cnt  <= '0;
        end else begin
            bubble_pend <= bubble_pend_d;
            if (flush && (head_valid || skid_valid) && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (bubble_ins && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default instance (skid, clear-data,
// 16-bit counters) and a small instance (no skid, data held, 4-bit counters)
// used for the combinational-ready, held-data and saturation cases.
module tb_pipe_stage_reg;
    import core_pipe_pkg::*;

    localparam int CW  = 9;
    localparam int DW  = 283;
    localparam int SDW = 16;

    localparam logic [CW-1:0] CTRL_A = 9'h011;
    localparam logic [CW-1:0] CTRL_B = 9'h022;
    localparam logic [CW-1:0] CTRL_C = 9'h033;
    localparam logic [CW-1:0] CTRL_D = CW'(1 << CTRL_MEMREAD) | CW'(1 << CTRL_REGWRITE);
    localparam logic [CW-1:0] CTRL_E = CW'(1 << CTRL_BRANCH) | CW'(3 << CTRL_ALUOP);

    logic           clk;
    logic           rst_n;
    logic           flush, bubble, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0]  in_ctrl, out_ctrl;
    logic [DW-1:0]  in_data, out_data;
    logic [15:0]    flush_cnt, bubble_cnt;

    logic           s_flush, s_bubble, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [CW-1:0]  s_in_ctrl, s_out_ctrl;
    logic [SDW-1:0] s_in_data, s_out_data;
    logic [3:0]     s_flush_cnt, s_bubble_cnt;

    int checks   = 0;
    int failures = 0;

    pipe_stage_reg u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bubble     (bubble),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
    );

    pipe_stage_reg #(
        .CTRL_W   (CW),
        .DATA_W   (SDW),
        .CLR_DATA (1'b0),
        .SKID_EN  (1'b0),
        .CNT_W    (4)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (s_flush),
        .bubble     (s_bubble),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_ctrl    (s_in_ctrl),
        .in_data    (s_in_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_ctrl   (s_out_ctrl),
        .out_data   (s_out_data),
        .flush_cnt  (s_flush_cnt),
        .bubble_cnt (s_bubble_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Payload with the PC in the top 64 bits and a PC-derived pattern below.
    function automatic logic [DW-1:0] mk_data(input logic [63:0] pc);
        return {pc, 219'(~pc)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        bubble     = 1'b0;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_ctrl    = 9'h1A5;
        in_data    = mk_data(64'h100);
        s_flush    = 1'b0;
        s_bubble   = 1'b0;
        s_in_valid = 1'b0;
        s_in_ctrl  = '0;
        s_in_data  = '0;
        s_out_ready = 1'b0;

        // 1: reset with in_valid high
        repeat (3) tick();
        check("rst_out_valid", 288'(out_valid), 288'(1'b0));
        check("rst_out_ctrl", 288'(out_ctrl), 288'(0));
        check("rst_out_data", 288'(out_data), 288'(0));
        check("rst_flush_cnt", 288'(flush_cnt), 288'(0));
        check("rst_bubble_cnt", 288'(bubble_cnt), 288'(0));
        check("rst_in_ready_low", 288'(in_ready), 288'(1'b0));
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("rel_in_ready", 288'(in_ready), 288'(1'b1));
        check("rel_out_valid", 288'(out_valid), 288'(1'b0));

        // 2: streaming, 10 back-to-back entries
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_ctrl  = 9'h1A5 + CW'(i);
            in_data  = mk_data(64'h100 + 64'(4 * i));
            tick();
            check($sformatf("stream%0d_valid", i), 288'(out_valid), 288'(1'b1));
            check($sformatf("stream%0d_ctrl", i), 288'(out_ctrl), 288'(9'h1A5 + CW'(i)));
            check($sformatf("stream%0d_data", i), 288'(out_data), 288'(mk_data(64'h100 + 64'(4 * i))));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", 288'(out_valid), 288'(1'b0));
        check("stream_drain_ctrl", 288'(out_ctrl), 288'(0));

        // 3: backpressure, A then B into head and skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = CTRL_A;
        in_data   = mk_data(64'h200);
        tick();
        check("bp_headA_ctrl", 288'(out_ctrl), 288'(CTRL_A));
        check("bp_ready_afterA", 288'(in_ready), 288'(1'b1));
        in_ctrl = CTRL_B;
        in_data = mk_data(64'h204);
        tick();
        check("bp_ready_afterB", 288'(in_ready), 288'(1'b0));
        check("bp_hold_ctrl", 288'(out_ctrl), 288'(CTRL_A));
        in_ctrl = CTRL_C;
        in_data = mk_data(64'h208);
        tick();
        check("bp_stable_ctrl", 288'(out_ctrl), 288'(CTRL_A));
        check("bp_stable_data", 288'(out_data), 288'(mk_data(64'h200)));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_B_valid", 288'(out_valid), 288'(1'b1));
        check("bp_B_ctrl", 288'(out_ctrl), 288'(CTRL_B));
        check("bp_B_data", 288'(out_data), 288'(mk_data(64'h204)));
        check("bp_ready_back", 288'(in_ready), 288'(1'b1));
        tick();
        check("bp_no_dup", 288'(out_valid), 288'(1'b0));

        // 4: flush with head = A, skid = B, C offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = CTRL_A;
        in_data   = mk_data(64'h200);
        tick();
        in_ctrl = CTRL_B;
        in_data = mk_data(64'h204);
        tick();
        check("fl_pre_ready", 288'(in_ready), 288'(1'b0));
        in_ctrl = CTRL_C;
        in_data = mk_data(64'h208);
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 288'(out_valid), 288'(1'b0));
        check("fl_out_ctrl", 288'(out_ctrl), 288'(0));
        check("fl_out_data", 288'(out_data), 288'(0));
        check("fl_cnt1", 288'(flush_cnt), 288'(16'd1));
        check("fl_ready_after", 288'(in_ready), 288'(1'b1));
        out_ready = 1'b1;
        tick();
        check("fl_skid_gone", 288'(out_valid), 288'(1'b0));
        // flush on an empty stage while an entry is accepted: entry dropped, count unchanged
        in_valid = 1'b1;
        in_ctrl  = CTRL_C;
        in_data  = mk_data(64'h208);
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_empty_cnt", 288'(flush_cnt), 288'(16'd1));
        check("fl_in_discard", 288'(out_valid), 288'(1'b0));

        // 5: bubble with D offered
        bubble   = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = CTRL_D;
        in_data  = mk_data(64'h300);
        #1;
        check("bub_ready_low", 288'(in_ready), 288'(1'b0));
        tick();
        bubble = 1'b0;
        check("bub_nop_valid", 288'(out_valid), 288'(1'b1));
        check("bub_nop_ctrl", 288'(out_ctrl), 288'(0));
        check("bub_nop_data", 288'(out_data), 288'(0));
        check("bub_cnt1", 288'(bubble_cnt), 288'(16'd1));
        #1;
        check("bub_ready_back", 288'(in_ready), 288'(1'b1));
        tick();
        in_valid = 1'b0;
        check("bub_D_ctrl", 288'(out_ctrl), 288'(CTRL_D));
        check("bub_D_data", 288'(out_data), 288'(mk_data(64'h300)));
        tick();
        check("bub_D_gone", 288'(out_valid), 288'(1'b0));

        // bubble held pending behind a stalled head, asserted twice
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = CTRL_E;
        in_data   = mk_data(64'h400);
        tick();
        in_valid = 1'b0;
        bubble   = 1'b1;
        tick();
        check("pend_hold_ctrl", 288'(out_ctrl), 288'(CTRL_E));
        check("pend_cnt_hold", 288'(bubble_cnt), 288'(16'd1));
        tick();
        bubble = 1'b0;
        tick();
        check("pend_hold2_ctrl", 288'(out_ctrl), 288'(CTRL_E));
        out_ready = 1'b1;
        tick();
        check("pend_nop_valid", 288'(out_valid), 288'(1'b1));
        check("pend_nop_ctrl", 288'(out_ctrl), 288'(0));
        check("pend_cnt2", 288'(bubble_cnt), 288'(16'd2));
        tick();
        check("pend_no_accum_valid", 288'(out_valid), 288'(1'b0));
        check("pend_no_accum_cnt", 288'(bubble_cnt), 288'(16'd2));

        // 6a: flush and bubble together on a live head: flush wins
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = CTRL_A;
        in_data   = mk_data(64'h500);
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        bubble   = 1'b1;
        tick();
        flush  = 1'b0;
        bubble = 1'b0;
        check("prio_valid", 288'(out_valid), 288'(1'b0));
        check("prio_bubble_cnt", 288'(bubble_cnt), 288'(16'd2));
        check("prio_flush_cnt", 288'(flush_cnt), 288'(16'd2));

        // Small instance: combinational ready, held data on flush
        s_in_valid = 1'b1;
        s_in_ctrl  = 9'h055;
        s_in_data  = 16'hBEEF;
        #1;
        check("s_ready_empty", 288'(s_in_ready), 288'(1'b1));
        tick();
        s_in_valid = 1'b0;
        #1;
        check("s_ready_stalled", 288'(s_in_ready), 288'(1'b0));
        s_out_ready = 1'b1;
        #1;
        check("s_ready_drain", 288'(s_in_ready), 288'(1'b1));
        s_out_ready = 1'b0;
        check("s_head_data", 288'(s_out_data), 288'(16'hBEEF));
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        check("s_fl_valid", 288'(s_out_valid), 288'(1'b0));
        check("s_fl_ctrl", 288'(s_out_ctrl), 288'(0));
        check("s_fl_data_held", 288'(s_out_data), 288'(16'hBEEF));
        check("s_fl_cnt1", 288'(s_flush_cnt), 288'(4'd1));

        // 6b: 16 counted flushes and 16 bubbles into 4-bit counters saturate at 4'hF
        for (int k = 0; k < 15; k++) begin
            s_in_valid = 1'b1;
            s_in_data  = SDW'(k);
            tick();
            s_in_valid = 1'b0;
            s_flush    = 1'b1;
            tick();
            s_flush    = 1'b0;
        end
        check("s_flush_sat", 288'(s_flush_cnt), 288'(4'hF));
        s_out_ready = 1'b1;
        s_bubble    = 1'b1;
        repeat (16) tick();
        s_bubble    = 1'b0;
        s_out_ready = 1'b0;
        check("s_bubble_sat", 288'(s_bubble_cnt), 288'(4'hF));
        check("s_nop_valid", 288'(s_out_valid), 288'(1'b1));
        check("s_nop_ctrl", 288'(s_out_ctrl), 288'(0));
        check("s_nop_data_held", 288'(s_out_data), 288'(16'd14));
        s_flush  = 1'b1;
        s_bubble = 1'b1;
        tick();
        s_flush  = 1'b0;
        s_bubble = 1'b0;
        check("s_prio_valid", 288'(s_out_valid), 288'(1'b0));
        check("s_prio_flush_cnt", 288'(s_flush_cnt), 288'(4'hF));
        check("s_prio_bubble_cnt", 288'(s_bubble_cnt), 288'(4'hF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
